// File: rtl/alu_share_ctrl_pkg.sv
// Shared types and constants for the two-requester mini-ALU controller.
package alu_ctrl_pkg;

   localparam int ALU_WIDTH = 6;
   localparam int ALU_FXN_W = 3;
   localparam int CNT_W     = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   // The controller never decodes these; they are here for requesters and benches.
   localparam logic [ALU_FXN_W-1:0] FXN_AND = 3'b000;
   localparam logic [ALU_FXN_W-1:0] FXN_OR  = 3'b001;
   localparam logic [ALU_FXN_W-1:0] FXN_XOR = 3'b010;
   localparam logic [ALU_FXN_W-1:0] FXN_EQ  = 3'b011;
   localparam logic [ALU_FXN_W-1:0] FXN_LT  = 3'b100;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request, response and ALU-side signals of the shared-ALU controller.
interface alu_share_ctrl_if #(
   parameter int WIDTH = 6,
   parameter int FXN_W = 3
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [FXN_W-1:0] req0_fxn;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [FXN_W-1:0] req1_fxn;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic             rsp_result;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [FXN_W-1:0] alu_fxn;
   logic             alu_result;
   logic             busy;

   // Environment side: requesters, response consumer and the ALU itself.
   modport master (
      output req0_valid, req0_a, req0_b, req0_fxn,
      output req1_valid, req1_a, req1_b, req1_fxn,
      output rsp_ready, alu_result,
      input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result,
      input  alu_a, alu_b, alu_fxn, busy
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_fxn,
      input  req1_valid, req1_a, req1_b, req1_fxn,
      input  rsp_ready, alu_result,
      output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result,
      output alu_a, alu_b, alu_fxn, busy
   );
endinterface

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: on a tie, the requester that did not win last time wins.
// Purely combinational, zero latency; it never holds anything back itself.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic       grant_valid,
   output logic       grant_id
);
   always_comb begin
      grant_valid = |valid;
      grant_id    = 1'b0;
      case (valid)
         2'b01:   grant_id = 1'b0;
         2'b10:   grant_id = 1'b1;
         2'b11:   grant_id = ~last_grant;
         default: grant_id = 1'b0;
      endcase
   end
endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one mini ALU between two requesters; accept at T gives rsp_valid at T+WAIT_CYCLES+1.
// One op in flight; a stalled response channel holds the FSM in RESP and blocks all new grants.
module alu_share_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH       = ALU_WIDTH,
   parameter int FXN_W       = ALU_FXN_W,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_share_ctrl_if.slave   bus
);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             last_grant;
   logic             grant_valid;
   logic             grant_id;
   logic             accept;

   rr_arb2 u_arb (
      .valid       ({bus.req1_valid, bus.req0_valid}),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   assign accept         = (state == IDLE) && grant_valid;
   assign bus.req0_ready = accept && !grant_id;
   assign bus.req1_ready = accept && grant_id;
   assign bus.busy       = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         last_grant     <= 1'b1;
         bus.rsp_valid  <= 1'b0;
         bus.rsp_id     <= 1'b0;
         bus.rsp_result <= 1'b0;
         bus.alu_a      <= '0;
         bus.alu_b      <= '0;
         bus.alu_fxn    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  bus.alu_a   <= grant_id ? bus.req1_a   : bus.req0_a;
                  bus.alu_b   <= grant_id ? bus.req1_b   : bus.req0_b;
                  bus.alu_fxn <= grant_id ? bus.req1_fxn : bus.req0_fxn;
                  bus.rsp_id  <= grant_id;
                  last_grant  <= grant_id;
                  cnt         <= CNT_INIT;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               // Only the result present on the last settle cycle is trusted.
               if (cnt == '0) begin
                  bus.rsp_result <= bus.alu_result;
                  bus.rsp_valid  <= 1'b1;
                  state          <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
